// File: rtl/bs_search_engine.sv
// Binary-search engine over an external sorted synchronous ROM.
// Controller FSM plus lo/hi/mid datapath; reports match, location and probe count.
module bs_search_engine #(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 5,
    parameter int DESCENDING = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] target,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] loc,
    output logic [ADDR_W:0]   probes
);
    localparam int PW = ADDR_W + 1;
    localparam logic [PW-1:0] LAST = PW'((1 << ADDR_W) - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WAIT, S_CMP, S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tgt_q, tgt_d;
    logic [PW-1:0]     lo_q, lo_d;
    logic [PW-1:0]     hi_q, hi_d;
    logic [PW-1:0]     probes_q, probes_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] loc_q, loc_d;
    logic              found_q, found_d;

    logic [PW-1:0] sum;
    logic [PW-1:0] mid;
    logic          eq, lt, go_up, up_end, dn_end, accept;

    assign sum    = lo_q + hi_q;
    assign mid    = sum >> 1;
    assign eq     = (rom_data == tgt_q);
    assign lt     = (rom_data < tgt_q);
    assign go_up  = (DESCENDING != 0) ? (!lt && !eq) : lt;
    // End-of-range tests stop lo/hi before they could wrap.
    assign up_end = (mid == LAST) || ((mid + ONE) > hi_q);
    assign dn_end = (mid == '0) || ((mid - ONE) < lo_q);
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            tgt_q    <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            probes_q <= '0;
            addr_q   <= '0;
            loc_q    <= '0;
            found_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tgt_q    <= tgt_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            probes_q <= probes_d;
            addr_q   <= addr_d;
            loc_q    <= loc_d;
            found_q  <= found_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_ADDR;
            S_ADDR: state_d = S_WAIT;
            S_WAIT: state_d = S_CMP;
            S_CMP: begin
                if (eq)
                    state_d = S_DONE;
                else if (go_up)
                    state_d = up_end ? S_DONE : S_ADDR;
                else
                    state_d = dn_end ? S_DONE : S_ADDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        tgt_d    = tgt_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        probes_d = probes_q;
        addr_d   = addr_q;
        loc_d    = loc_q;
        found_d  = found_q;
        if (accept) begin
            tgt_d    = target;
            lo_d     = '0;
            hi_d     = LAST;
            probes_d = '0;
            loc_d    = '0;
            found_d  = 1'b0;
        end
        if (state_q == S_ADDR)
            addr_d = mid[ADDR_W-1:0];
        if (state_q == S_CMP) begin
            probes_d = probes_q + ONE;
            if (eq) begin
                found_d = 1'b1;
                loc_d   = mid[ADDR_W-1:0];
            end else if (go_up && !up_end) begin
                lo_d = mid + ONE;
            end else if (!go_up && !dn_end) begin
                hi_d = mid - ONE;
            end
        end
    end

    always_comb begin
        busy = (state_q == S_ADDR) || (state_q == S_WAIT) || (state_q == S_CMP);
        done = (state_q == S_DONE);
    end

    assign rom_addr = addr_q;
    assign found    = found_q;
    assign loc      = loc_q;
    assign probes   = probes_q;

endmodule

// File: tb/tb_bs_search_engine.sv
// Bench for bs_search_engine: ascending and descending instances, each with
// its own synchronous ROM, checked against a behavioural binary-search model.
module tb_bs_search_engine;
    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_d;
    logic [DW-1:0] target;

    logic [AW-1:0] addr_a, addr_d, loc_a, loc_d;
    logic [DW-1:0] rom_a, rom_d;
    logic busy_a, busy_d, done_a, done_d, found_a, found_d;
    logic [AW:0] probes_a, probes_d;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_a <= mem_a[addr_a];
        rom_d <= mem_d[addr_d];
    end

    bs_search_engine #(.DATA_W(DW), .ADDR_W(AW), .DESCENDING(0)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .target(target),
        .rom_addr(addr_a), .rom_data(rom_a), .busy(busy_a), .done(done_a),
        .found(found_a), .loc(loc_a), .probes(probes_a)
    );

    bs_search_engine #(.DATA_W(DW), .ADDR_W(AW), .DESCENDING(1)) dut_d (
        .clk(clk), .reset(reset), .start(start_d), .target(target),
        .rom_addr(addr_d), .rom_data(rom_d), .busy(busy_d), .done(done_d),
        .found(found_d), .loc(loc_d), .probes(probes_d)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Plain binary search over the array, as the algorithm is described.
    task automatic model(input bit desc, input int t,
                         output int f, output int l, output int p);
        int lo, hi, mid, v;
        bit up;
        lo = 0; hi = DEPTH - 1; p = 0; f = 0; l = 0;
        forever begin
            mid = (lo + hi) / 2;
            v = desc ? int'(mem_d[mid]) : int'(mem_a[mid]);
            p++;
            if (v == t) begin
                f = 1; l = mid;
                break;
            end
            up = desc ? (v > t) : (v < t);
            if (up) begin
                if (mid == DEPTH - 1 || mid + 1 > hi) break;
                lo = mid + 1;
            end else begin
                if (mid == 0 || mid - 1 < lo) break;
                hi = mid - 1;
            end
        end
    endtask

    task automatic run(input bit desc, input int t,
                       output int f, output int l, output int p, output int cyc);
        @(negedge clk);
        target = DW'(t);
        if (desc) start_d = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_d = 1'b0;
        cyc = 1;
        chk("done_drop", desc ? done_d : done_a, 0);
        chk("busy_set", desc ? busy_d : busy_a, 1);
        while (!(desc ? done_d : done_a) && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("timeout", desc ? done_d : done_a, 1);
        f = desc ? int'(found_d) : int'(found_a);
        l = desc ? int'(loc_d) : int'(loc_a);
        p = desc ? int'(probes_d) : int'(probes_a);
    endtask

    task automatic check_search(input bit desc, input int t);
        int f, l, p, cyc, ef, el, ep;
        model(desc, t, ef, el, ep);
        run(desc, t, f, l, p, cyc);
        chk($sformatf("found[d%0d t%0d]", desc, t), f, ef);
        chk($sformatf("loc[d%0d t%0d]", desc, t), l, el);
        chk($sformatf("probes[d%0d t%0d]", desc, t), p, ep);
        chk($sformatf("latency[d%0d t%0d]", desc, t), cyc, 3 * ep + 1);
    endtask

    task automatic directed(input bit desc, input int t,
                            input int ef, input int el, input int ep);
        int f, l, p, cyc;
        run(desc, t, f, l, p, cyc);
        chk($sformatf("dir_found[t%0d]", t), f, ef);
        chk($sformatf("dir_loc[t%0d]", t), l, el);
        chk($sformatf("dir_probes[t%0d]", t), p, ep);
        chk($sformatf("dir_lat[t%0d]", t), cyc, 3 * ep + 1);
    endtask

    initial begin
        int f, l, p, cyc, v;
        reset = 1'b0;
        start_a = 1'b0;
        start_d = 1'b0;
        target = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = DW'(2 * i + 2);
            mem_d[i] = DW'(64 - 2 * i);
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_found", found_a, 0);
        chk("rst_loc", loc_a, 0);
        chk("rst_probes", probes_a, 0);
        chk("rst_addr", addr_a, 0);
        reset = 1'b1;

        directed(0, 32, 1, 15, 1);
        directed(0, 2, 1, 0, 5);
        directed(0, 64, 1, 31, 6);
        directed(0, 65, 0, 0, 6);
        directed(0, 1, 0, 0, 5);
        directed(0, 33, 0, 0, 5);

        // Second start mid-search with a new target must be ignored.
        @(negedge clk);
        target = 8'd2;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (4) @(negedge clk);
        target = 8'd4;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("ign_busy", busy_a, 1);
        cyc = 0;
        while (!done_a && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("ign_timeout", done_a, 1);
        chk("ign_found", found_a, 1);
        chk("ign_loc", loc_a, 0);
        chk("ign_probes", probes_a, 5);

        // Reset in the middle of a search.
        @(negedge clk);
        target = 8'd2;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_busy_pre", busy_a, 1);
        reset = 1'b0;
        @(negedge clk);
        chk("mrst_busy", busy_a, 0);
        chk("mrst_done", done_a, 0);
        chk("mrst_found", found_a, 0);
        chk("mrst_loc", loc_a, 0);
        chk("mrst_probes", probes_a, 0);
        chk("mrst_addr", addr_a, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("mrst_idle", done_a, 0);

        // Descending; consecutive runs start straight from DONE.
        directed(1, 64, 1, 0, 5);
        directed(1, 2, 1, 31, 6);
        directed(1, 33, 0, 0, 5);
        directed(1, 0, 0, 0, 6);
        run(1, 40, f, l, p, cyc);
        chk("b2b_found", f, 1);
        chk("b2b_loc", l, 12);

        // Random sorted images, duplicates allowed.
        for (int img = 0; img < 4; img++) begin
            v = $urandom_range(0, 20);
            for (int i = 0; i < DEPTH; i++) begin
                v += $urandom_range(0, 3);
                mem_a[i] = DW'(v);
                mem_d[DEPTH - 1 - i] = DW'(v + 50);
            end
            for (int k = 0; k < 10; k++) begin
                if ($urandom_range(0, 1) == 1)
                    check_search(0, int'(mem_a[$urandom_range(0, DEPTH - 1)]));
                else
                    check_search(0, $urandom_range(0, 255));
                if ($urandom_range(0, 1) == 1)
                    check_search(1, int'(mem_d[$urandom_range(0, DEPTH - 1)]));
                else
                    check_search(1, $urandom_range(0, 255));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
